// File: rtl/division_restoring_signed.sv
// Sequential signed divider: sign/magnitude split, restoring shift-subtract
// (one quotient bit per clock), then sign fix-up and a one-cycle done pulse.
module division_restoring_signed #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] first_nr,
  input  logic [WIDTH-1:0] second_nr,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned      CW       = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t           state_q;
  logic             sign_quo_q;
  logic             sign_rem_q;
  logic             zero_q;
  logic             ovf_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   prem_q;
  logic [CW-1:0]    count_q;

  logic [WIDTH-1:0] mag_a_d;
  logic [WIDTH-1:0] mag_b_d;
  logic [WIDTH:0]   shifted_d;
  logic [WIDTH+1:0] diff_d;
  logic             qbit_d;
  logic [WIDTH:0]   prem_d;
  logic [WIDTH-1:0] dvd_d;
  logic [WIDTH-1:0] quo_fix_d;
  logic [WIDTH-1:0] rem_fix_d;
  logic [WIDTH-1:0] rem_dz_d;

  always_comb begin
    mag_a_d   = first_nr[WIDTH-1]  ? -first_nr  : first_nr;
    mag_b_d   = second_nr[WIDTH-1] ? -second_nr : second_nr;
    // dvd_q shifts out dividend bits at the top and collects quotient bits at the bottom
    shifted_d = {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    diff_d    = {1'b0, shifted_d} - {2'b00, dvs_q};
    qbit_d    = ~diff_d[WIDTH+1];
    prem_d    = qbit_d ? diff_d[WIDTH:0] : shifted_d;
    dvd_d     = {dvd_q[WIDTH-2:0], qbit_d};
    quo_fix_d = sign_quo_q ? -dvd_q : dvd_q;
    rem_fix_d = sign_rem_q ? -prem_q[WIDTH-1:0] : prem_q[WIDTH-1:0];
    // on a zero divisor dvd_q still holds |first_nr|; re-applying its sign restores first_nr
    rem_dz_d  = sign_rem_q ? -dvd_q : dvd_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      sign_quo_q  <= 1'b0;
      sign_rem_q  <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      count_q     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sign_quo_q  <= first_nr[WIDTH-1] ^ second_nr[WIDTH-1];
            sign_rem_q  <= first_nr[WIDTH-1];
            dvd_q       <= mag_a_d;
            dvs_q       <= mag_b_d;
            prem_q      <= '0;
            count_q     <= '0;
            zero_q      <= (second_nr == '0);
            ovf_q       <= (first_nr == MOST_NEG) && (second_nr == '1);
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            busy        <= 1'b1;
            state_q     <= (second_nr == '0) ? FIX : ITER;
          end
        end
        ITER: begin
          prem_q  <= prem_d;
          dvd_q   <= dvd_d;
          count_q <= count_q + 1'b1;
          if (count_q == CW'(WIDTH - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          quotient    <= zero_q ? '0 : quo_fix_d;
          remainder   <= zero_q ? rem_dz_d : rem_fix_d;
          div_by_zero <= zero_q;
          overflow    <= ovf_q;
          done        <= 1'b1;
          busy        <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_division_restoring_signed.sv
// Bench for division_restoring_signed: directed cases plus random operands
// checked against an integer-arithmetic reference model.
module tb_division_restoring_signed;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] first_nr;
  logic [W-1:0] second_nr;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  division_restoring_signed #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_nr   (first_nr),
    .second_nr  (second_nr),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: truncating signed division; remainder follows the dividend.
  task automatic model(input int a, input int b, output int q, output int r,
                       output int dz, output int ov);
    dz = 0;
    ov = 0;
    if (b == 0) begin
      q  = 0;
      r  = a;
      dz = 1;
    end else if (a == -(1 << (W - 1)) && b == -1) begin
      q  = a;
      r  = 0;
      ov = 1;
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  function automatic int pat(input int v);
    return v & ((1 << W) - 1);
  endfunction

  task automatic wait_done(output int cycles, output int bcnt);
    cycles = 0;
    bcnt   = 0;
    while (!done && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
      if (busy) bcnt++;
    end
  endtask

  task automatic check_result(input string tag, input int a, input int b,
                              input int cyc, input int bcnt);
    int q, r, dz, ov, lat;
    model(a, b, q, r, dz, ov);
    lat = (dz != 0) ? 1 : W + 1;
    check({tag, " latency"}, cyc, lat);
    check({tag, " busy_cycles"}, bcnt, lat);
    check({tag, " busy_at_done"}, int'(busy), 0);
    check({tag, " quotient"}, int'(quotient), pat(q));
    check({tag, " remainder"}, int'(remainder), pat(r));
    check({tag, " div_by_zero"}, int'(div_by_zero), dz);
    check({tag, " overflow"}, int'(overflow), ov);
  endtask

  // now=1 launches in the current (done-high) cycle instead of the next negedge
  task automatic do_div(input string tag, input int a, input int b, input bit now);
    int cyc, bcnt;
    if (!now) @(negedge clk);
    first_nr  = a[W-1:0];
    second_nr = b[W-1:0];
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    first_nr  = W'($urandom);
    second_nr = W'($urandom);
    check({tag, " done_drop"}, int'(done), 0);
    wait_done(cyc, bcnt);
    check_result(tag, a, b, cyc, bcnt + int'(busy === 1'b0 ? 1 : 0));
  endtask

  initial begin
    int cyc, bcnt, dones;
    logic [W-1:0] hold_q;
    rst       = 1'b0;
    start     = 1'b0;
    first_nr  = '0;
    second_nr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset quotient", int'(quotient), 0);
    check("reset remainder", int'(remainder), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset div_by_zero", int'(div_by_zero), 0);
    check("reset overflow", int'(overflow), 0);
    @(negedge clk);
    rst = 1'b1;

    do_div("7/2", 7, 2, 1'b0);
    hold_q = quotient;
    repeat (3) @(posedge clk);
    #1;
    check("done pulse width", int'(done), 0);
    check("hold quotient", int'(quotient), int'(hold_q));

    do_div("-7/2", -7, 2, 1'b0);
    do_div("7/-2", 7, -2, 1'b0);
    do_div("6/-3", 6, -3, 1'b0);
    do_div("0/5", 0, 5, 1'b0);
    do_div("5/0", 5, 0, 1'b0);
    do_div("-8/0", -8, 0, 1'b0);
    do_div("-8/-1", -8, -1, 1'b0);
    do_div("-8/1", -8, 1, 1'b0);
    do_div("b2b 3/2", 3, 2, 1'b1);

    // start pulsed mid-operation must be ignored
    @(negedge clk);
    first_nr = 4'd7; second_nr = 4'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    first_nr = 4'd1; second_nr = 4'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(cyc, bcnt);
    check("ignore latency", cyc, 3);
    check("ignore quotient", int'(quotient), 3);
    check("ignore remainder", int'(remainder), 1);

    // reset mid-operation abandons the division
    @(negedge clk);
    first_nr = 4'd7; second_nr = 4'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst quotient", int'(quotient), 0);
    check("midrst remainder", int'(remainder), 0);
    check("midrst busy", int'(busy), 0);
    check("midrst done", int'(done), 0);
    @(negedge clk);
    rst   = 1'b1;
    dones = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("midrst no_done", dones, 0);
    do_div("4/2", 4, 2, 1'b0);

    for (int i = 0; i < 120; i++) begin
      int a, b;
      a = int'($urandom_range(15)) - 8;
      b = int'($urandom_range(15)) - 8;
      do_div($sformatf("rand %0d/%0d", a, b), a, b, 1'(($urandom_range(1))));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/division_restoring_signed.md
Name: division_restoring_signed

Overview:
- Sequential signed divider for the calculator datapath.
- Consumes the two 4-bit two's-complement operands (first_nr = dividend, second_nr = divisor) registered by the division complement stage.
- Produces quotient and remainder with shift-subtract restoring division: one quotient bit per clock.
- Results go to the display/result stage, with a one-cycle done pulse and error flags.

Parameters:
- WIDTH, 4, operand/result width in bits (two's complement)

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous reset, active-low: block resets on a rising clk edge while rst=0
- start  input  1  request; sampled only in IDLE
- first_nr  input  WIDTH  dividend, two's complement
- second_nr  input  WIDTH  divisor, two's complement
- quotient  output  WIDTH  signed quotient, registered
- remainder  output  WIDTH  signed remainder, registered
- busy  output  1  high from the accepting edge until the edge that asserts done
- done  output  1  one-cycle pulse; results valid from this cycle until the next accepted start
- div_by_zero  output  1  sticky with results; set when second_nr=0
- overflow  output  1  sticky with results; set for most-negative / -1

Behaviour:
- Reset (rst=0 at clk edge):
  - state=IDLE.
  - quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, overflow=0.
  - All internal registers cleared.
  - Reset has priority over everything, including mid-operation: the division is abandoned and no done is produced.
- States: IDLE, ITER, FIX.
- IDLE:
  - On an edge with start=1 (edge E0), latch the operands.
  - sign_q = msb(first_nr) XOR msb(second_nr); sign_r = msb(first_nr).
  - Latch magnitudes |first_nr| and |second_nr| as unsigned WIDTH-bit values. The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which fits unsigned.
  - Clear the WIDTH+1-bit partial remainder; count=0.
  - Clear div_by_zero, overflow and done; busy=1.
  - If second_nr=0: go to FIX with the zero-divisor marker set. Otherwise go to ITER.
- ITER (edges E1..E_WIDTH):
  - Each edge: shift {partial remainder, dividend magnitude} left by 1.
  - Trial-subtract the divisor magnitude from the partial remainder.
  - Non-negative: keep the difference and set quotient bit = 1. Negative: restore and set the bit = 0.
  - count increments each edge; after WIDTH iterations go to FIX.
- FIX (edge E_WIDTH+1):
  - Negate the magnitude quotient if sign_q=1; negate the remainder if sign_r=1.
  - Division truncates toward zero. The remainder takes the sign of the dividend; a zero remainder is 0.
  - Register quotient/remainder; done=1 for exactly this cycle; busy=0; return to IDLE.
- Latency:
  - Normal case: done is high in the cycle after edge E_WIDTH+1, i.e. WIDTH+1 edges after acceptance (5 for WIDTH=4).
  - Divide by zero: done after E1.
- Divide by zero:
  - quotient=0, remainder=first_nr unchanged, div_by_zero=1, overflow=0.
- Overflow (first_nr=-2^(WIDTH-1), second_nr=-1):
  - quotient=-2^(WIDTH-1) (wrapped bit pattern), remainder=0, overflow=1.
- start while busy: ignored; operands are not re-sampled.
- start asserted in the same cycle done is high: accepted, since the state is IDLE at that edge. done drops on that edge.
- Operand inputs are don't-care except at the accepting edge.
- Outputs hold their last values in IDLE until the next acceptance. Acceptance clears the flags only; quotient and remainder are overwritten at FIX.

Test Plan:
- first_nr=0111 (7), second_nr=0010 (2), start pulse -> after 5 edges done=1, quotient=0011, remainder=0001, flags 0; busy high for exactly 5 cycles.
- first_nr=1001 (-7), second_nr=0010 -> quotient=1101 (-3), remainder=1111 (-1). Then 0111 / 1110 (7 / -2) -> quotient=1101, remainder=0001.
- first_nr=0110, second_nr=1101 (6 / -3) -> quotient=1110 (-2), remainder=0000. Then 0000 / 0101 -> quotient=0000, remainder=0000.
- first_nr=0101, second_nr=0000 -> done after 1 edge, div_by_zero=1, quotient=0000, remainder=0101.
- first_nr=1000, second_nr=1111 (-8 / -1) -> overflow=1, quotient=1000, remainder=0000. Then 1000 / 0001 -> quotient=1000, remainder=0000, overflow=0.
- Start 7/2; at the 2nd ITER edge pulse start with 1/1 -> ignored, result still 3 r 1. Start again and drive rst=0 at the 3rd edge -> all outputs 0, no done pulse. Then start 4/2 -> quotient=0010, remainder=0000.
